calculador_peso: RTL and testbench
==================================

# calculador_peso

Inverse of the scale's price computation: given a customer budget in cents and the price per kilogram in cents, computes how many net grams the budget buys and the gross weight to show on the scale, including the fixed 40 g tare. Sits beside the price multiplier in the scale datapath. It is driven by the keypad/controller through a start/done handshake. A serial restoring divider keeps the logic small, at the cost of fixed multi-cycle latency.

## Interface
- TARA, 40: tare in grams, fixed value of the scale (((2+1+4+3+7+2+3)%9)*10).
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- orcamento  in  14  budget in cents (0..16383).
- centimos  in  9  price per kg in cents (0..511).
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse; results valid from this cycle until the next accepted start.
- pesoliquido  out  14  net grams = floor(orcamento*1000/centimos), saturated at 16383.
- pesobruto  out  14  min(pesoliquido + TARA, 16383).
- resto  out  9  remainder (orcamento*1000) mod centimos; 0 when saturated or on error.
- saturado  out  1  quotient exceeded 16383.
- erro  out  1  centimos was 0.

## Operation
- States: IDLE, DIV, FIM.
- IDLE + start=1: latch orcamento and centimos, then branch:
  - If centimos==0, go to FIM with the error path.
  - Otherwise compute dividend = orcamento*1000 (24 bits, max 16,383,000), clear the partial remainder (10 bits), load the counter with 23, and go to DIV.
- DIV: one restoring step per cycle, MSB first:
  - r = {r, dividend bit}.
  - If r >= divisor, then r = r - divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - After 24 steps (counter reaches 0), go to FIM.
- FIM (lasts exactly one cycle):
  - Register outputs and pulse done=1. Busy is already low.
  - Return to IDLE. A start seen in this same cycle is not accepted; it is accepted from the next cycle.
- Output rules at FIM:
  - Quotient is 24 bits. If quotient > 16383: pesoliquido=16383, pesobruto=16383, saturado=1, resto=0.
  - Else: pesoliquido=quotient, pesobruto=min(quotient+40, 16383), resto=remainder.
  - Error path: pesoliquido=0, pesobruto=0, resto=0, saturado=0, erro=1.
  - saturado and erro are mutually exclusive and are cleared on the next accepted start.
- start while busy is ignored. Inputs may change after acceptance without effect.
- orcamento=0 is legal: pesoliquido=0, pesobruto=40.

## Timing
- Reset: state=IDLE, busy=0, done=0, pesoliquido=0, pesobruto=0, resto=0, saturado=0, erro=0, counter=0.
- rst overrides everything, including mid-DIV. The bench sees the reset values on the cycle after the rst edge, with no done pulse.
- Normal latency: start accepted at edge E0.
  - busy=1 from E0.
  - DIV steps at edges E1..E24.
  - At E25: busy=0, done=1, outputs valid.
  - done=0 at E26.
- Error latency: start at E0 (busy=1). At E1: done=1, erro=1, busy=0.
- Throughput: next start accepted at the earliest at E26, i.e. one request every 26 cycles.
- Outputs hold their values between done pulses. They change only at a done edge or on reset.

## Test plan
- orcamento=500, centimos=250, one start pulse:
  - Required at E25: done=1, pesoliquido=2000, pesobruto=2040, resto=0, saturado=0, erro=0.
  - busy high for exactly 25 cycles.
- orcamento=1234, centimos=511:
  - Required: pesoliquido=2414, pesobruto=2454, resto=446.
- orcamento=100, centimos=3 (quotient 33333):
  - Required: saturado=1, pesoliquido=16383, pesobruto=16383, resto=0.
- centimos=0, orcamento=999:
  - Required at E1: done=1, erro=1, all numeric outputs 0.
  - A following valid request clears erro.
- Start with 500/250; pulse start again at E5 with 1234/511; assert rst for one cycle at E10:
  - Second start ignored.
  - After reset all outputs are 0, no done pulse appears, and the block is in IDLE.
- Back-to-back: hold start high continuously with orcamento=0, centimos=7:
  - Required: done pulses 26 cycles apart, pesoliquido=0, pesobruto=40 each time.

Source files
------------

// File: rtl/calculador_peso_if.sv
`default_nettype none
// ============================================================================
// Module      : calculador_peso_if
// Description : Start/done request bus between the keypad controller and
//               the weight calculator.
// Revision    : 1.0 - initial release
// ============================================================================
interface calculador_peso_if;
    logic        start;
    logic [13:0] orcamento;
    logic [8:0]  centimos;
    logic        busy;
    logic        done;
    logic [13:0] pesoliquido;
    logic [13:0] pesobruto;
    logic [8:0]  resto;
    logic        saturado;
    logic        erro;

    modport master (
        output start, orcamento, centimos,
        input  busy, done, pesoliquido, pesobruto, resto, saturado, erro
    );

    modport slave (
        input  start, orcamento, centimos,
        output busy, done, pesoliquido, pesobruto, resto, saturado, erro
    );
endinterface
`default_nettype wire

// File: rtl/calculador_peso.sv
`default_nettype none
// ============================================================================
// Module      : calculador_peso
// Description : Budget-to-weight calculator: floor(orcamento*1000/centimos)
//               via a 24-step serial restoring divider, plus fixed tare.
// Revision    : 1.0 - initial release
// ============================================================================
module calculador_peso #(
    parameter int TARA = 40
) (
    input  wire logic          clk,
    input  wire logic          rst,
    calculador_peso_if.slave   bus
);

    localparam logic [1:0]  IDLE      = 2'd0;
    localparam logic [1:0]  DIV       = 2'd1;
    localparam logic [1:0]  FIM       = 2'd2;
    localparam logic [4:0]  LAST_STEP = 5'd23;
    localparam logic [13:0] PESO_MAX  = 14'h3FFF;
    localparam logic [14:0] TARA_W    = 15'(TARA);

    logic [1:0]  state_q,    state_d;
    logic [4:0]  cnt_q,      cnt_d;
    logic [23:0] dividend_q, dividend_d;
    logic [8:0]  divisor_q,  divisor_d;
    logic [8:0]  rem_q,      rem_d;
    logic        done_q,     done_d;
    logic [13:0] liq_q,      liq_d;
    logic [13:0] bruto_q,    bruto_d;
    logic [8:0]  resto_q,    resto_d;
    logic        sat_q,      sat_d;
    logic        erro_q,     erro_d;

    logic        w_accept;
    logic [23:0] w_product;
    logic [9:0]  w_shift;
    logic [9:0]  w_diff;
    logic        w_ge;
    logic        w_unused_msb;
    logic        w_quot_sat;
    logic [14:0] w_sum;
    logic [13:0] w_bruto;

    assign w_accept  = (state_q == IDLE) && bus.start;
    assign w_product = {10'd0, bus.orcamento} * 24'd1000;

    // Dividend register shifts left; freed LSBs collect the quotient bits.
    assign w_shift      = {rem_q, dividend_q[23]};
    assign w_ge         = (w_shift >= {1'b0, divisor_q});
    assign w_diff       = w_shift - {1'b0, divisor_q};
    assign w_unused_msb = w_diff[9];

    assign w_quot_sat = |dividend_q[23:14];
    assign w_sum      = {1'b0, dividend_q[13:0]} + TARA_W;
    assign w_bruto    = (w_sum > {1'b0, PESO_MAX}) ? PESO_MAX : w_sum[13:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            dividend_q <= 24'd0;
            divisor_q  <= 9'd0;
            rem_q      <= 9'd0;
            done_q     <= 1'b0;
            liq_q      <= 14'd0;
            bruto_q    <= 14'd0;
            resto_q    <= 9'd0;
            sat_q      <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            liq_q      <= liq_d;
            bruto_q    <= bruto_d;
            resto_q    <= resto_d;
            sat_q      <= sat_d;
            erro_q     <= erro_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = (bus.centimos == 9'd0) ? FIM : DIV;
                end
            end
            DIV: begin
                if (cnt_q == 5'd0) begin
                    state_d = FIM;
                end
            end
            FIM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        liq_d      = liq_q;
        bruto_d    = bruto_q;
        resto_d    = resto_q;
        sat_d      = sat_q;
        erro_d     = erro_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    dividend_d = w_product;
                    divisor_d  = bus.centimos;
                    rem_d      = 9'd0;
                    cnt_d      = LAST_STEP;
                    sat_d      = 1'b0;
                    erro_d     = 1'b0;
                end
            end
            DIV: begin
                dividend_d = {dividend_q[22:0], w_ge};
                rem_d      = w_ge ? w_diff[8:0] : w_shift[8:0];
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            FIM: begin
                done_d = 1'b1;
                if (divisor_q == 9'd0) begin
                    liq_d   = 14'd0;
                    bruto_d = 14'd0;
                    resto_d = 9'd0;
                    sat_d   = 1'b0;
                    erro_d  = 1'b1;
                end else if (w_quot_sat) begin
                    liq_d   = PESO_MAX;
                    bruto_d = PESO_MAX;
                    resto_d = 9'd0;
                    sat_d   = 1'b1;
                    erro_d  = 1'b0;
                end else begin
                    liq_d   = dividend_q[13:0];
                    bruto_d = w_bruto;
                    resto_d = rem_q;
                    sat_d   = 1'b0;
                    erro_d  = 1'b0;
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.pesoliquido = liq_q;
    assign bus.pesobruto   = bruto_q;
    assign bus.resto       = resto_q;
    assign bus.saturado    = sat_q;
    assign bus.erro        = erro_q;

endmodule
`default_nettype wire

// File: tb/tb_calculador_peso.sv
`default_nettype none
// ============================================================================
// Module      : tb_calculador_peso
// Description : Directed vector bench for calculador_peso.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calculador_peso;

    typedef struct {
        logic [13:0] orc;
        logic [8:0]  cent;
        int          liq;
        int          bruto;
        int          resto;
        int          sat;
        int          erro;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   prev_liq = 0;
    vec_t vecs[13];

    calculador_peso_if bus ();

    calculador_peso #(.TARA(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int liq, input int bruto,
                              input int resto, input int sat, input int erro);
        check({tag, ".liq"},   int'(bus.pesoliquido), liq);
        check({tag, ".bruto"}, int'(bus.pesobruto),   bruto);
        check({tag, ".resto"}, int'(bus.resto),       resto);
        check({tag, ".sat"},   int'(bus.saturado),    sat);
        check({tag, ".erro"},  int'(bus.erro),        erro);
    endtask

    // Waits for done; returns cycles after acceptance and busy-high count.
    task automatic wait_done(output int lat, output int busy_cnt);
        bit seen = 1'b0;
        lat      = 0;
        busy_cnt = int'(bus.busy);
        for (int n = 1; n <= 60 && !seen; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                lat  = n;
            end else if (bus.busy) begin
                busy_cnt++;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int busy_cnt;
        bus.start     = 1'b1;
        bus.orcamento = v.orc;
        bus.centimos  = v.cent;
        @(posedge clk); @(negedge clk);
        bus.start     = 1'b0;
        bus.orcamento = 14'($urandom);
        bus.centimos  = 9'($urandom);
        check({tag, ".busy_e0"}, int'(bus.busy), 1);
        check({tag, ".flags_clr"}, int'({bus.saturado, bus.erro}), 0);
        check({tag, ".hold_liq"}, int'(bus.pesoliquido), prev_liq);
        wait_done(lat, busy_cnt);
        check({tag, ".latency"}, lat, v.lat);
        check({tag, ".busy_cycles"}, busy_cnt, v.lat);
        check({tag, ".busy_at_done"}, int'(bus.busy), 0);
        check_outs(tag, v.liq, v.bruto, v.resto, v.sat, v.erro);
        @(posedge clk); @(negedge clk);
        check({tag, ".done_drop"}, int'(bus.done), 0);
        check({tag, ".hold_after"}, int'(bus.pesoliquido), v.liq);
        prev_liq = v.liq;
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int dones;
        int t[3];
        int k;
        vec_t v7;

        vecs[0]  = '{14'd500,   9'd250, 2000,  2040,  0,   0, 0, 25};
        vecs[1]  = '{14'd1234,  9'd511, 2414,  2454,  446, 0, 0, 25};
        vecs[2]  = '{14'd100,   9'd3,   16383, 16383, 0,   1, 0, 25};
        vecs[3]  = '{14'd999,   9'd0,   0,     0,     0,   0, 1, 1};
        vecs[4]  = '{14'd500,   9'd250, 2000,  2040,  0,   0, 0, 25};
        vecs[5]  = '{14'd0,     9'd7,   0,     40,    0,   0, 0, 25};
        vecs[6]  = '{14'd2047,  9'd125, 16376, 16383, 0,   0, 0, 25};
        vecs[7]  = '{14'd2048,  9'd125, 16383, 16383, 0,   1, 0, 25};
        vecs[8]  = '{14'd998,   9'd61,  16360, 16383, 40,  0, 0, 25};
        vecs[9]  = '{14'd7,     9'd3,   2333,  2373,  1,   0, 0, 25};
        vecs[10] = '{14'd16383, 9'd511, 16383, 16383, 0,   1, 0, 25};
        vecs[11] = '{14'd16383, 9'd0,   0,     0,     0,   0, 1, 1};
        vecs[12] = '{14'd1,     9'd511, 1,     41,    489, 0, 0, 25};
        v7       = vecs[9];

        bus.start     = 1'b0;
        bus.orcamento = 14'd0;
        bus.centimos  = 9'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset.busy", int'(bus.busy), 0);
        check("reset.done", int'(bus.done), 0);
        check_outs("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Second start during DIV must not disturb the first request.
        bus.start = 1'b1; bus.orcamento = 14'd500; bus.centimos = 9'd250;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        bus.start = 1'b1; bus.orcamento = 14'd1234; bus.centimos = 9'd511;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, busy_cnt);
        check("ignore.latency", lat + 5, 25);
        check_outs("ignore", 2000, 2040, 0, 0, 0);
        @(posedge clk); @(negedge clk);

        // Reset in the middle of DIV.
        bus.start = 1'b1; bus.orcamento = 14'd500; bus.centimos = 9'd250;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        bus.start = 1'b1; bus.orcamento = 14'd1234; bus.centimos = 9'd511;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("midrst.busy", int'(bus.busy), 0);
        check("midrst.done", int'(bus.done), 0);
        check_outs("midrst", 0, 0, 0, 0, 0);
        dones = 0;
        busy_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); @(negedge clk);
            dones    += int'(bus.done);
            busy_cnt += int'(bus.busy);
        end
        check("midrst.no_done", dones, 0);
        check("midrst.idle", busy_cnt, 0);
        prev_liq = 0;
        run_vec(v7, "post_rst");

        // Start held high: one result every 26 cycles.
        bus.start = 1'b1; bus.orcamento = 14'd0; bus.centimos = 9'd7;
        k = 0;
        for (int n = 0; n < 120 && k < 3; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus.done) begin
                t[k] = cyc;
                check($sformatf("b2b%0d.liq", k), int'(bus.pesoliquido), 0);
                check($sformatf("b2b%0d.bruto", k), int'(bus.pesobruto), 40);
                k++;
            end
        end
        bus.start = 1'b0;
        check("b2b.count", k, 3);
        if (k == 3) begin
            check("b2b.gap01", t[1] - t[0], 26);
            check("b2b.gap12", t[2] - t[1], 26);
        end
        repeat (30) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
